// File: rtl/jtag_uart_tx_arbiter.sv
// Avalon-MM master that shares one JTAG UART transmit data register among NUM_REQ
// byte streams, with packet-granular round-robin and poll-refreshed write credit.
module jtag_uart_tx_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int POLL_GAP = 16,
    parameter int IDW      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   av_address,
    output logic                   av_chipselect,
    output logic                   av_read_n,
    output logic                   av_write_n,
    output logic [31:0]            av_writedata,
    input  logic [31:0]            av_readdata,
    input  logic                   av_waitrequest,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [PW:0]   NUM_EXT  = (PW+1)'(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_POLL, S_GAP, S_WRITE} state_t;

    state_t          r_state, w_state_next;
    logic [6:0]      r_credit, w_credit_next;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_next;
    logic [PW-1:0]   r_grant, w_grant_next;
    logic            r_busy, w_busy_next;
    logic [GW-1:0]   r_gap_cnt, w_gap_cnt_next;
    logic            r_cs, w_cs_next;
    logic            r_read_n, w_read_n_next;
    logic            r_write_n, w_write_n_next;
    logic            r_addr, w_addr_next;
    logic [7:0]      r_wbyte, w_wbyte_next;

    logic [7:0]          w_byte [NUM_REQ];
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]  w_rot;
    logic [PW-1:0]       w_off;
    logic [PW:0]         w_sum;
    logic [PW-1:0]       w_pick;
    logic                w_any;
    logic                w_complete;
    logic [6:0]          w_space;
    logic                w_unused_rd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotate the valid vector so rr_ptr sits at bit 0; the lowest set bit is the winner.
    assign w_dbl = {req_valid, req_valid};
    assign w_rot = NUM_REQ'(w_dbl >> r_rr_ptr);
    assign w_any = |req_valid;

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PW'(k);
            end
        end
    end

    assign w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_pick = (w_sum >= NUM_EXT) ? PW'(w_sum - NUM_EXT) : w_sum[PW-1:0];

    assign w_complete  = r_cs & ~av_waitrequest;
    assign w_space     = (av_readdata[31:16] > 16'd64) ? 7'd64 : av_readdata[22:16];
    assign w_unused_rd = ^av_readdata[15:0];

    always_comb begin
        w_state_next   = r_state;
        w_credit_next  = r_credit;
        w_rr_ptr_next  = r_rr_ptr;
        w_grant_next   = r_grant;
        w_busy_next    = r_busy;
        w_gap_cnt_next = r_gap_cnt;
        w_cs_next      = r_cs;
        w_read_n_next  = r_read_n;
        w_write_n_next = r_write_n;
        w_addr_next    = r_addr;
        w_wbyte_next   = r_wbyte;
        req_ready      = '0;

        case (r_state)
            S_IDLE: begin
                if (!r_busy) begin
                    if (w_any) begin
                        w_grant_next = w_pick;
                        w_busy_next  = 1'b1;
                    end
                end else if (req_valid[r_grant]) begin
                    // Commands launch on the transition so the bus sees them one cycle earlier.
                    if (r_credit != 7'd0) begin
                        w_state_next   = S_WRITE;
                        w_cs_next      = 1'b1;
                        w_write_n_next = 1'b0;
                        w_addr_next    = 1'b0;
                        w_wbyte_next   = w_byte[r_grant];
                    end else begin
                        w_state_next  = S_POLL;
                        w_cs_next     = 1'b1;
                        w_read_n_next = 1'b0;
                        w_addr_next   = 1'b1;
                    end
                end
            end
            S_POLL: begin
                if (w_complete) begin
                    w_cs_next      = 1'b0;
                    w_read_n_next  = 1'b1;
                    w_addr_next    = 1'b0;
                    w_credit_next  = w_space;
                    w_gap_cnt_next = '0;
                    w_state_next   = (w_space != 7'd0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GW'(POLL_GAP - 1)) begin
                    w_state_next  = S_POLL;
                    w_cs_next     = 1'b1;
                    w_read_n_next = 1'b0;
                    w_addr_next   = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end
            S_WRITE: begin
                if (w_complete) begin
                    w_cs_next          = 1'b0;
                    w_write_n_next     = 1'b1;
                    req_ready[r_grant] = 1'b1;
                    w_credit_next      = r_credit - 7'd1;
                    w_state_next       = S_IDLE;
                    if (req_last[r_grant]) begin
                        w_busy_next   = 1'b0;
                        w_rr_ptr_next = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_credit  <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
            r_cs      <= 1'b0;
            r_read_n  <= 1'b1;
            r_write_n <= 1'b1;
            r_addr    <= 1'b0;
            r_wbyte   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_credit  <= w_credit_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_grant   <= w_grant_next;
            r_busy    <= w_busy_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_cs      <= w_cs_next;
            r_read_n  <= w_read_n_next;
            r_write_n <= w_write_n_next;
            r_addr    <= w_addr_next;
            r_wbyte   <= w_wbyte_next;
        end
    end

    assign av_chipselect = r_cs;
    assign av_read_n     = r_read_n;
    assign av_write_n    = r_write_n;
    assign av_address    = r_addr;
    assign av_writedata  = {24'h0, r_wbyte};
    assign grant_id      = IDW'(r_grant);
    assign busy          = r_busy;

endmodule

// File: tb/tb_jtag_uart_tx_arbiter.sv
// Bench for jtag_uart_tx_arbiter: behavioural JTAG UART slave, requester drivers,
// and a write scoreboard with an independent credit model.
module tb_jtag_uart_tx_arbiter;
    localparam int NUM_REQ  = 2;
    localparam int POLL_GAP = 16;
    localparam int IDW      = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 av_address;
    logic                 av_chipselect;
    logic                 av_read_n;
    logic                 av_write_n;
    logic [31:0]          av_writedata;
    logic [31:0]          av_readdata;
    logic                 av_waitrequest;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    jtag_uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .POLL_GAP(POLL_GAP), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_read_n(av_read_n),
        .av_write_n(av_write_n), .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_waitrequest(av_waitrequest), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]        wdata;
        logic [NUM_REQ-1:0] ready;
    } exp_t;

    typedef struct {
        int                 r;
        logic [7:0]         data;
        logic               last;
        logic [31:0]        exp_wdata;
        logic [NUM_REQ-1:0] exp_ready;
    } vec_t;

    vec_t        vt [8];
    exp_t        exp_q [$];
    exp_t        e;
    logic [15:0] space_q [$];

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int slave_delay = 1;
    int wait_cnt = 0;
    int model_credit = 0;
    int n_polls = 0;
    int n_gaps = 0;
    int n_pulses [NUM_REQ];
    int last_poll_done = 0;
    bit last_poll_zero = 0;
    bit prev_hold = 0;
    bit prev_cs = 0;
    logic        prev_addr, prev_rn, prev_wn;
    logic [31:0] prev_wd;
    logic [15:0] sp;
    bit seen;
    bit got;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Slave: waitrequest idles high, drops for one cycle after slave_delay stalled cycles.
    initial begin
        av_waitrequest = 1'b1;
        av_readdata    = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!av_waitrequest) begin
                av_waitrequest = 1'b1;
            end else if (av_chipselect && !reset) begin
                if (wait_cnt >= slave_delay) begin
                    wait_cnt = 0;
                    av_waitrequest = 1'b0;
                    if (!av_read_n) begin
                        if (space_q.size() > 0) sp = space_q.pop_front();
                        else sp = 16'h0040;
                        av_readdata = {sp, 16'h1234};
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: stability, completions, scoreboard, credit model, poll gap.
    initial begin
        for (int r = 0; r < NUM_REQ; r++) n_pulses[r] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 0; prev_cs = 0; model_credit = 0; last_poll_zero = 0;
                continue;
            end
            if (prev_hold) begin
                if (!(av_chipselect && av_address == prev_addr && av_read_n == prev_rn &&
                      av_write_n == prev_wn && av_writedata == prev_wd)) begin
                    n_miss++;
                    $display("FAIL hold_stable cyc=%0d got cs=%b a=%b rn=%b wn=%b wd=%h, required cs=1 a=%b rn=%b wn=%b wd=%h",
                             cyc, av_chipselect, av_address, av_read_n, av_write_n, av_writedata,
                             prev_addr, prev_rn, prev_wn, prev_wd);
                end
            end
            if (av_chipselect && !prev_cs && !av_read_n && last_poll_zero) begin
                n_vec++; n_gaps++;
                if (cyc - last_poll_done - 1 != POLL_GAP) begin
                    n_miss++;
                    $display("FAIL poll_gap got %0d idle cycles, required %0d", cyc - last_poll_done - 1, POLL_GAP);
                end
            end
            if (av_chipselect && !av_waitrequest) begin
                if (!av_write_n) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL write_unexpected got wd=%h ready=%b, required no write", av_writedata, req_ready);
                    end else begin
                        e = exp_q.pop_front();
                        if (av_writedata !== e.wdata || req_ready !== e.ready || av_address !== 1'b0) begin
                            n_miss++;
                            $display("FAIL write got wd=%h ready=%b addr=%b, required wd=%h ready=%b addr=0",
                                     av_writedata, req_ready, av_address, e.wdata, e.ready);
                        end
                    end
                    if (model_credit <= 0) begin
                        n_miss++;
                        $display("FAIL write_credit got write at credit %0d, required credit>0", model_credit);
                    end else begin
                        model_credit--;
                    end
                    $display("cyc=%0d write wd=%h ready=%b credit_left=%0d", cyc, av_writedata, req_ready, model_credit);
                end else if (!av_read_n) begin
                    n_polls++;
                    sp = av_readdata[31:16];
                    model_credit = (sp > 16'd64) ? 64 : int'(sp);
                    last_poll_zero = (sp == 16'd0);
                    last_poll_done = cyc;
                    if (av_address !== 1'b1 || req_ready !== '0) begin
                        n_miss++;
                        $display("FAIL poll got addr=%b ready=%b, required addr=1 ready=0", av_address, req_ready);
                    end
                    $display("cyc=%0d poll space=%h", cyc, sp);
                end
            end else if (req_ready !== '0) begin
                n_miss++;
                $display("FAIL ready_spurious cyc=%0d got ready=%b, required 0", cyc, req_ready);
            end
            for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) n_pulses[r]++;
            prev_hold = av_chipselect && av_waitrequest;
            prev_cs   = av_chipselect;
            prev_addr = av_address; prev_rn = av_read_n; prev_wn = av_write_n; prev_wd = av_writedata;
        end
    end

    function automatic void push_exp(input logic [31:0] wd, input logic [NUM_REQ-1:0] rdy);
        exp_t x;
        x.wdata = wd;
        x.ready = rdy;
        exp_q.push_back(x);
    endfunction

    task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] req_v);
        n_vec++;
        if (got_v !== req_v) begin
            n_miss++;
            $display("FAIL %s got %h, required %h", name, got_v, req_v);
        end else begin
            $display("check %s = %h", name, got_v);
        end
    endtask

    task automatic send_byte(input int r, input logic [7:0] d, input logic last);
        bit ok = 0;
        req_data[8*r +: 8] = d;
        req_last[r]  = last;
        req_valid[r] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (req_ready[r]) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL ready_timeout req%0d byte %h got no accept, required one", r, d);
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    task automatic send_pkt(input int r, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(r, base + 8'(i), i == n - 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !av_chipselect) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL idle_timeout got %0d writes pending busy=%b, required 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        space_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 8'h41, 1'b0, 32'h0000_0041, 2'b01};
        vt[1] = '{0, 8'h42, 1'b0, 32'h0000_0042, 2'b01};
        vt[2] = '{0, 8'h43, 1'b1, 32'h0000_0043, 2'b01};
        vt[3] = '{0, 8'h50, 1'b0, 32'h0000_0050, 2'b01};
        vt[4] = '{0, 8'h51, 1'b0, 32'h0000_0051, 2'b01};
        vt[5] = '{0, 8'h52, 1'b0, 32'h0000_0052, 2'b01};
        vt[6] = '{0, 8'h53, 1'b1, 32'h0000_0053, 2'b01};
        vt[7] = '{1, 8'h7E, 1'b1, 32'h0000_007E, 2'b10};

        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({av_chipselect, av_read_n, av_write_n, av_address, av_writedata, req_ready, grant_id, busy}),
              64'({1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0}));
        reset = 1'b0;

        // Single requester packet, one poll returning 64.
        n_polls = 0; n_pulses[0] = 0;
        space_q.push_back(16'h0040);
        for (int i = 0; i < 3; i++) begin
            push_exp(vt[i].exp_wdata, vt[i].exp_ready);
            send_byte(vt[i].r, vt[i].data, vt[i].last);
        end
        wait_idle();
        check("t1_polls", 64'(n_polls), 64'd1);
        check("t1_credit", 64'(dut.r_credit), 64'd61);
        check("t1_pulses", 64'(n_pulses[0]), 64'd3);
        check("t1_busy", 64'(busy), 64'd0);

        // Simultaneous contention, twice, from rr_ptr=0.
        do_reset();
        for (int round = 0; round < 2; round++) begin
            push_exp(32'h11 + 32'(round * 4), 2'b01);
            push_exp(32'h12 + 32'(round * 4), 2'b01);
            push_exp(32'h21 + 32'(round * 4), 2'b10);
            push_exp(32'h22 + 32'(round * 4), 2'b10);
            fork
                send_pkt(0, 8'h11 + 8'(round * 4), 2);
                send_pkt(1, 8'h21 + 8'(round * 4), 2);
            join
            wait_idle();
        end

        // Zero-space polls, then credit of 2 forcing a re-poll mid-packet.
        do_reset();
        n_polls = 0; n_gaps = 0;
        space_q.push_back(16'h0000);
        space_q.push_back(16'h0000);
        space_q.push_back(16'h0002);
        for (int i = 3; i < 7; i++) begin
            push_exp(vt[i].exp_wdata, vt[i].exp_ready);
            send_byte(vt[i].r, vt[i].data, vt[i].last);
        end
        wait_idle();
        check("t3_polls", 64'(n_polls), 64'd4);
        check("t3_gap_checks", 64'(n_gaps), 64'd2);

        // Long stall on a write.
        slave_delay = 10;
        n_pulses[0] = 0; n_pulses[1] = 0;
        push_exp(vt[7].exp_wdata, vt[7].exp_ready);
        send_byte(vt[7].r, vt[7].data, vt[7].last);
        wait_idle();
        slave_delay = 1;
        check("t4_pulses", 64'({n_pulses[1][7:0], n_pulses[0][7:0]}), 64'h0100);

        // Owner pauses mid-packet while req1 waits.
        push_exp(32'h60, 2'b01);
        push_exp(32'h61, 2'b01);
        push_exp(32'h62, 2'b01);
        push_exp(32'h70, 2'b10);
        fork
            begin
                send_byte(0, 8'h60, 1'b0);
                repeat (20) @(posedge clk);
                #1;
                send_byte(0, 8'h61, 1'b0);
                send_byte(0, 8'h62, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                send_byte(1, 8'h70, 1'b1);
            end
            begin
                repeat (14) @(negedge clk);
                check("t5_hold_grant", 64'({busy, grant_id, av_chipselect}), 64'({1'b1, 1'b0, 1'b0}));
            end
        join
        wait_idle();

        // Reset while a write is stalled.
        slave_delay = 50;
        req_data[7:0] = 8'h99; req_last[0] = 1'b1; req_valid[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (av_chipselect && !av_write_n) begin seen = 1; break; end
        end
        check("t6_write_pending", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_reset",
              64'({av_chipselect, av_read_n, av_write_n, av_address, av_writedata, req_ready, grant_id, busy}),
              64'({1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0}));
        req_valid = '0; req_last = '0;
        exp_q.delete();
        slave_delay = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_exp(32'h5A, 2'b01);
        got = 0;
        fork
            send_byte(0, 8'h5A, 1'b1);
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    if (av_chipselect) begin got = 1; break; end
                end
                check("t6_first_cmd", 64'({got, av_read_n, av_write_n, av_address}),
                      64'({1'b1, 1'b0, 1'b1, 1'b1}));
            end
        join
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
